// File: rtl/norm_shift_detect.sv
// Purpose : sequential normalizer; shifts a 16-bit operand toward MSB (dir=1) or LSB (else) until the end bit is 1, reporting word, count and zero flag.
// Latency : done strobes k+1 edges after the start edge for k shifts (ceil(k/2)+1 with NORM_FAST_EN); zero operand completes one edge after start.
// Backpr. : none; start is sampled only in IDLE, and a start while SHIFT/DONE is dropped (not queued). Optional macro: NORM_FAST_EN (two-bit steps).
module norm_shift_detect #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] src,
    input  logic [1:0]       dir,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       shamt,
    output logic             zr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] w_q, w_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             left_q, left_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [3:0]       shamt_q, shamt_d;
    logic             zr_q, zr_d;
    logic             target_bit;
`ifdef NORM_FAST_EN
    logic             pair_clr;
`endif

    // State and datapath registers; reset aborts any operation without a done strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            cnt_q   <= 4'd0;
            left_q  <= 1'b0;
            out_q   <= '0;
            shamt_q <= 4'd0;
            zr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            out_q   <= out_d;
            shamt_q <= shamt_d;
            zr_q    <= zr_d;
        end
    end

    // Next-state logic: capture on start, shift toward the target end, publish results on completion.
    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        cnt_d      = cnt_q;
        left_d     = left_q;
        out_d      = out_q;
        shamt_d    = shamt_q;
        zr_d       = zr_q;
        target_bit = left_q ? w_q[WIDTH-1] : w_q[0];
`ifdef NORM_FAST_EN
        // Both bits at the target end clear means at least two more shifts are needed.
        pair_clr   = left_q ? (w_q[WIDTH-1:WIDTH-2] == 2'b00) : (w_q[1:0] == 2'b00);
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (src == '0) begin
                        state_d = S_DONE;
                        out_d   = '0;
                        shamt_d = 4'd0;
                        zr_d    = 1'b1;
                    end else begin
                        state_d = S_SHIFT;
                        w_d     = src;
                        cnt_d   = 4'd0;
                        zr_d    = 1'b0;
                        // Only 2'd1 selects MSB; every other code normalizes toward LSB.
                        left_d  = (dir == 2'd1);
                    end
                end
            end
            S_SHIFT: begin
                if (target_bit) begin
                    state_d = S_DONE;
                    out_d   = w_q;
                    shamt_d = cnt_q;
                end else begin
`ifdef NORM_FAST_EN
                    if (pair_clr) begin
                        w_d   = left_q ? (w_q << 2) : (w_q >> 2);
                        cnt_d = cnt_q + 4'd2;
                    end else begin
                        w_d   = left_q ? (w_q << 1) : (w_q >> 1);
                        cnt_d = cnt_q + 4'd1;
                    end
`else
                    w_d   = left_q ? (w_q << 1) : (w_q >> 1);
                    cnt_d = cnt_q + 4'd1;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy  = (state_q == S_SHIFT);
    assign done  = (state_q == S_DONE);
    assign out   = out_q;
    assign shamt = shamt_q;
    assign zr    = zr_q;

endmodule

// File: tb/tb_norm_shift_detect.sv
// Self-checking bench for norm_shift_detect: latency-countdown reference model compared every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_norm_shift_detect;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] src;
    logic [1:0]  dir;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic [3:0]  shamt;
    logic        zr;

`ifdef NORM_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    always #5 clk = ~clk;

    norm_shift_detect #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .src   (src),
        .dir   (dir),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .shamt (shamt),
        .zr    (zr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic int lt(input int slow, input int fast);
        return FAST ? fast : slow;
    endfunction

    // Reference: count shifts until the target end bit is 1 (bounded; only called with nonzero operands).
    function automatic void norm_ref(input logic [15:0] s, input logic left,
                                     output logic [15:0] o, output int k);
        o = s;
        k = 0;
        while ((left ? !o[15] : !o[0]) && k < 16) begin
            o = left ? (o << 1) : (o >> 1);
            k++;
        end
    endfunction

    // Model: 0 idle, 1 running (countdown of edges to completion), 2 done cycle.
    int          m_mode = 0;
    int          m_rem  = 0;
    int          m_k    = 0;
    bit          m_valid = 1'b0;
    logic [15:0] m_out = '0, m_pend_out = '0;
    logic [3:0]  m_shamt = '0, m_pend_sh = '0;
    logic        m_zr = 1'b0;

    always @(posedge clk) begin
        m_valid = 1'b1;
        if (rst) begin
            m_mode  = 0;
            m_out   = '0;
            m_shamt = '0;
            m_zr    = 1'b0;
        end else begin
            case (m_mode)
                0: if (start) begin
                    if (src == 16'h0000) begin
                        m_mode  = 2;
                        m_out   = '0;
                        m_shamt = '0;
                        m_zr    = 1'b1;
                    end else begin
                        norm_ref(src, dir == 2'd1, m_pend_out, m_k);
                        m_pend_sh = m_k[3:0];
                        m_rem     = FAST ? ((m_k + 1) / 2 + 1) : (m_k + 1);
                        m_zr      = 1'b0;
                        m_mode    = 1;
                    end
                end
                1: begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_mode  = 2;
                        m_out   = m_pend_out;
                        m_shamt = m_pend_sh;
                    end
                end
                default: m_mode = 0;
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_busy",  busy,  m_mode == 1);
            chk("cyc_done",  done,  m_mode == 2);
            chk("cyc_out",   out,   m_out);
            chk("cyc_shamt", shamt, m_shamt);
            chk("cyc_zr",    zr,    m_zr);
        end
    end

    // One operation: pulse start, wait (bounded) for done, check literals, then confirm no extra done.
    // inject_at > 0 fires a second start (src=0x0001) that many cycles into the wait.
    task automatic run_op(input string nm, input logic [15:0] s, input logic [1:0] d,
                          input logic [15:0] eo, input logic [3:0] es, input logic ez,
                          input int elat, input int inject_at);
        int c;
        int pulses;
        bit got;
        src   = s;
        dir   = d;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        c = 0;
        got = 1'b0;
        pulses = 0;
        while (!got && c < 40) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
            end else begin
                c++;
                if (c == inject_at) begin
                    src   = 16'h0001;
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done_within_40", nm);
        end else begin
            chk({nm, "_lat"},   c,     elat);
            chk({nm, "_out"},   out,   eo);
            chk({nm, "_shamt"}, shamt, es);
            chk({nm, "_zr"},    zr,    ez);
        end
        repeat (4) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk({nm, "_extra_done"}, pulses, 0);
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        src   = '0;
        dir   = 2'd0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",  busy,  1'b0);
        chk("rst_done",  done,  1'b0);
        chk("rst_out",   out,   16'h0000);
        chk("rst_shamt", shamt, 4'd0);
        chk("rst_zr",    zr,    1'b0);
        @(posedge clk);
        #2;

        run_op("l_0001",  16'h0001, 2'd1, 16'h8000, 4'd15, 1'b0, lt(16, 9), 0);
        run_op("l_8000",  16'h8000, 2'd1, 16'h8000, 4'd0,  1'b0, lt(1, 1),  0);
        run_op("zero_d2", 16'h0000, 2'd2, 16'h0000, 4'd0,  1'b1, 0,         0);
        run_op("r_00f0",  16'h00F0, 2'd2, 16'h000F, 4'd4,  1'b0, lt(5, 3),  0);
        run_op("zero_d1", 16'h0000, 2'd1, 16'h0000, 4'd0,  1'b1, 0,         0);
        run_op("r3_00f0", 16'h00F0, 2'd3, 16'h000F, 4'd4,  1'b0, lt(5, 3),  0);
        run_op("r0_00f0", 16'h00F0, 2'd0, 16'h000F, 4'd4,  1'b0, lt(5, 3),  0);
        run_op("l_1234",  16'h1234, 2'd1, 16'h91A0, 4'd3,  1'b0, lt(4, 3),  0);
        run_op("busy_ign",16'h0100, 2'd1, 16'h8000, 4'd7,  1'b0, lt(8, 5),  2);

        // Reset on the 5th busy cycle aborts the operation and clears the results.
        src   = 16'h0001;
        dir   = 2'd1;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("abort_busy_before", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy",  busy,  1'b0);
        chk("abort_done",  done,  1'b0);
        chk("abort_out",   out,   16'h0000);
        chk("abort_shamt", shamt, 4'd0);
        begin
            int pulses = 0;
            repeat (20) begin
                @(negedge clk);
                if (done) pulses++;
            end
            chk("abort_no_done", pulses, 0);
        end
        @(posedge clk);
        #2;
        run_op("post_rst", 16'h0030, 2'd2, 16'h0003, 4'd4, 1'b0, lt(5, 3), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
